// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg / alu / alu_arbiter
//
// Two requesters share a single ALU. The arbiter runs a three-state FSM
// (IDLE -> EXEC -> RESP). In IDLE it latches the winning requester's operands
// into internal registers. In EXEC it captures the ALU result and flags. In
// RESP it pulses rsp_valid for the owner. On a tie the requester that did not
// own the ALU last time wins.
//
// alu_arbiter ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   req[1:0]         per-requester request, held until its rsp_valid bit
//   op_a0/op_b0      requester 0 operands   (DATA_W)
//   op_a1/op_b1      requester 1 operands   (DATA_W)
//   opsel0/opsel1    per-requester ALU operation select (OPSEL_W)
//   gnt[1:0]         registered one-hot grant
//   busy             high in EXEC and RESP
//   rsp_valid[1:0]   one-cycle pulse on the owner's bit with the result
//   result           registered ALU result (DATA_W)
//   ovf, cf, zero    registered ALU flags captured with result
// -----------------------------------------------------------------------------

package alu_arbiter_pkg;
  localparam int ALU_OPSEL_W = 4;

  typedef enum logic [ALU_OPSEL_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_op_e;
endpackage

// -----------------------------------------------------------------------------
// alu: purely combinational.
//   op_a, op_b   operands (DATA_W)
//   alu_opsel    operation (alu_op_e encoding)
//   res          result (DATA_W)
//   ovf          signed overflow (ADD/SUB only)
//   cf           carry out for ADD, borrow (op_a < op_b unsigned) for SUB
//   zero         res == 0
// Shifts use the low $clog2(DATA_W) bits of op_b as the shift amount.
// -----------------------------------------------------------------------------
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]      op_a,
  input  logic [DATA_W-1:0]      op_b,
  input  logic [ALU_OPSEL_W-1:0] alu_opsel,
  output logic [DATA_W-1:0]      res,
  output logic                   ovf,
  output logic                   cf,
  output logic                   zero
);
  localparam int SHW = $clog2(DATA_W);

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [SHW-1:0]    sh_amt;

  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
  assign sh_amt   = op_b[SHW-1:0];

  // NOTE: every output of a combinational block is given a default before the
  // case statement so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    cf  = 1'b0;
    case (alu_opsel)
      ALU_ADD: begin
        res = sum_ext[DATA_W-1:0];
        cf  = sum_ext[DATA_W];
        ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
              (sum_ext[DATA_W-1] != op_a[DATA_W-1]);
      end
      ALU_SUB: begin
        res = diff_ext[DATA_W-1:0];
        cf  = diff_ext[DATA_W];
        ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
              (diff_ext[DATA_W-1] != op_a[DATA_W-1]);
      end
      ALU_AND: res = op_a & op_b;
      ALU_OR:  res = op_a | op_b;
      ALU_XOR: res = op_a ^ op_b;
      ALU_SLL: res = op_a << sh_amt;
      ALU_SRL: res = op_a >> sh_amt;
      ALU_SRA: res = DATA_W'($signed(op_a) >>> sh_amt);
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);
endmodule

// -----------------------------------------------------------------------------
// alu_arbiter: top level, see the file header for the port list.
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OPSEL_W = ALU_OPSEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [DATA_W-1:0]  op_a0,
  input  logic [DATA_W-1:0]  op_b0,
  input  logic [DATA_W-1:0]  op_a1,
  input  logic [DATA_W-1:0]  op_b1,
  input  logic [OPSEL_W-1:0] opsel0,
  input  logic [OPSEL_W-1:0] opsel1,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic [1:0]         rsp_valid,
  output logic [DATA_W-1:0]  result,
  output logic               ovf,
  output logic               cf,
  output logic               zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q,      state_d;
  logic [1:0]          gnt_q,        gnt_d;
  logic [1:0]          rsp_valid_q,  rsp_valid_d;
  logic [DATA_W-1:0]   result_q,     result_d;
  logic                ovf_q,        ovf_d;
  logic                cf_q,         cf_d;
  logic                zero_q,       zero_d;
  logic [DATA_W-1:0]   op_a_q,       op_a_d;
  logic [DATA_W-1:0]   op_b_q,       op_b_d;
  logic [OPSEL_W-1:0]  opsel_q,      opsel_d;
  logic                last_owner_q, last_owner_d;  // index of the previous owner

  logic [DATA_W-1:0]   alu_res;
  logic                alu_ovf;
  logic                alu_cf;
  logic                alu_zero;
  logic                winner;

  // The ALU sees only the latched operands, so input changes after the grant
  // cannot disturb an operation in flight.
  alu #(.DATA_W(DATA_W)) u_alu (
    .op_a      (op_a_q),
    .op_b      (op_b_q),
    .alu_opsel (ALU_OPSEL_W'(opsel_q)),
    .res       (alu_res),
    .ovf       (alu_ovf),
    .cf        (alu_cf),
    .zero      (alu_zero)
  );

  // A tie goes to the requester that did not own the ALU last; a single
  // request simply wins.
  assign winner = (req == 2'b11) ? ~last_owner_q : req[1];

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rsp_valid_d  = rsp_valid_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    cf_d         = cf_q;
    zero_d       = zero_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    opsel_d      = opsel_q;
    last_owner_d = last_owner_q;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          op_a_d       = winner ? op_a1  : op_a0;
          op_b_d       = winner ? op_b1  : op_b0;
          opsel_d      = winner ? opsel1 : opsel0;
          gnt_d        = winner ? 2'b10  : 2'b01;
          last_owner_d = winner;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d    = alu_res;
        ovf_d       = alu_ovf;
        cf_d        = alu_cf;
        zero_d      = alu_zero;
        rsp_valid_d = gnt_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        gnt_d       = 2'b00;
        rsp_valid_d = 2'b00;
        state_d     = ST_IDLE;
      end
      default: begin
        gnt_d       = 2'b00;
        rsp_valid_d = 2'b00;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  // NOTE: the operand registers are reset along with the control state so the
  // ALU inputs are defined immediately after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'b00;
      rsp_valid_q  <= 2'b00;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      cf_q         <= 1'b0;
      zero_q       <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      opsel_q      <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      cf_q         <= cf_d;
      zero_q       <= zero_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      opsel_q      <= opsel_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign cf        = cf_q;
  assign zero      = zero_q;

endmodule
